// File: rtl/conv_pe_ctrl_pkg.sv
// Shared constants and state encoding for the 3x3 PE sequencer.
package conv_pe_ctrl_pkg;

    localparam int KTAPS  = 9;
    localparam int PROD_W = 25;
    localparam int WGT_W  = 16;
    // Nine full-width products need clog2(9)=4 bits of headroom.
    localparam int KSUM_W = PROD_W + $clog2(KTAPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_e;

endpackage

// File: rtl/conv_pe_ctrl_if.sv
// Bus bundle between the sequencer, weight SRAM, line buffer, PE array and output writer.
interface conv_pe_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int PIX_W  = 16,
    parameter int SUM_W  = conv_pe_ctrl_pkg::KSUM_W
);
    logic                                   start;
    logic [ADDR_W-1:0]                      cfg_wbase;
    logic [PIX_W-1:0]                       cfg_nker;
    logic [PIX_W-1:0]                       cfg_npix;
    logic                                   cfg_relu;
    logic                                   busy;
    logic                                   done;
    logic                                   w_rd;
    logic [ADDR_W-1:0]                      w_addr;
    logic signed [conv_pe_ctrl_pkg::WGT_W-1:0]  w_data;
    logic                                   pe_kernel_rf_en;
    logic [conv_pe_ctrl_pkg::WGT_W-1:0]     pe_kernel_data;
    logic signed [conv_pe_ctrl_pkg::PROD_W-1:0] prod0, prod1, prod2, prod3, prod4,
                                                prod5, prod6, prod7, prod8;
    logic                                   win_valid;
    logic                                   win_ready;
    logic [SUM_W-1:0]                       out_data;
    logic                                   out_valid;
    logic                                   out_ready;

    modport master (
        input  start, cfg_wbase, cfg_nker, cfg_npix, cfg_relu, w_data,
               prod0, prod1, prod2, prod3, prod4, prod5, prod6, prod7, prod8,
               win_valid, out_ready,
        output busy, done, w_rd, w_addr, pe_kernel_rf_en, pe_kernel_data,
               win_ready, out_data, out_valid
    );

    modport slave (
        output start, cfg_wbase, cfg_nker, cfg_npix, cfg_relu, w_data,
               prod0, prod1, prod2, prod3, prod4, prod5, prod6, prod7, prod8,
               win_valid, out_ready,
        input  busy, done, w_rd, w_addr, pe_kernel_rf_en, pe_kernel_data,
               win_ready, out_data, out_valid
    );
endinterface

// File: rtl/conv_pe_ctrl_pe_sum_tree.sv
// Combinational 9-input signed adder tree with optional ReLU clamp.
module pe_sum_tree
    import conv_pe_ctrl_pkg::*;
#(
    parameter int SUM_W = KSUM_W
) (
    input  logic [KTAPS-1:0][PROD_W-1:0] prod_i,
    input  logic                         relu_i,
    output logic [SUM_W-1:0]             sum_o
);

    logic [KTAPS-1:0][SUM_W-1:0] ext;
    logic [3:0][SUM_W-1:0]       lvl1;
    logic [1:0][SUM_W-1:0]       lvl2;
    logic [SUM_W-1:0]            lvl3;
    logic [SUM_W-1:0]            total;

    for (genvar g = 0; g < KTAPS; g++) begin : g_ext
        assign ext[g] = {{(SUM_W-PROD_W){prod_i[g][PROD_W-1]}}, prod_i[g]};
    end

    // Pairwise reduction of taps 0..7; tap 8 joins at the root.
    for (genvar g = 0; g < 4; g++) begin : g_l1
        assign lvl1[g] = ext[2*g] + ext[2*g+1];
    end

    for (genvar g = 0; g < 2; g++) begin : g_l2
        assign lvl2[g] = lvl1[2*g] + lvl1[2*g+1];
    end

    assign lvl3  = lvl2[0] + lvl2[1];
    assign total = lvl3 + ext[KTAPS-1];
    assign sum_o = (relu_i && total[SUM_W-1]) ? '0 : total;

endmodule

// File: rtl/conv_pe_ctrl.sv
// Sequencer for the 3x3 PE array: loads each kernel's weights, streams windows, registers sums.
module conv_pe_ctrl
    import conv_pe_ctrl_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int PIX_W  = 16,
    parameter int SUM_W  = KSUM_W
) (
    input  logic           clk,
    input  logic           rst,
    conv_pe_ctrl_if.master bus
);

    localparam logic [3:0] TAP_LAST = 4'(KTAPS);

    state_e               state_q, state_d;
    logic [3:0]           tap_q, tap_d;
    logic [PIX_W-1:0]     ker_q, ker_d;
    logic [PIX_W-1:0]     pix_q, pix_d;
    logic [PIX_W-1:0]     nker_q, nker_d;
    logic [PIX_W-1:0]     npix_q, npix_d;
    logic [ADDR_W-1:0]    kbase_q, kbase_d;
    logic                 relu_q, relu_d;
    logic [SUM_W-1:0]     out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;

    logic                 win_ready;
    logic                 accept;
    logic                 last_ker;
    logic                 last_pix;
    logic                 adv_ker;
    logic                 w_rd;
    logic [ADDR_W-1:0]    w_addr;
    logic                 rf_en;
    logic [WGT_W-1:0]     kdata;
    logic                 done;
    logic [SUM_W-1:0]     sum;
    logic [KTAPS-1:0][PROD_W-1:0] prod;

    assign prod = {bus.prod8, bus.prod7, bus.prod6, bus.prod5, bus.prod4,
                   bus.prod3, bus.prod2, bus.prod1, bus.prod0};

    pe_sum_tree #(.SUM_W(SUM_W)) u_sum (
        .prod_i (prod),
        .relu_i (relu_q),
        .sum_o  (sum)
    );

    assign win_ready = (state_q == S_RUN) && (!out_valid_q || bus.out_ready);
    assign accept    = bus.win_valid && win_ready;
    assign last_ker  = (ker_q == nker_q - PIX_W'(1));
    assign last_pix  = (pix_q == npix_q - PIX_W'(1));

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        ker_d   = ker_q;
        pix_d   = pix_q;
        nker_d  = nker_q;
        npix_d  = npix_q;
        kbase_d = kbase_q;
        relu_d  = relu_q;
        adv_ker = 1'b0;
        w_rd    = 1'b0;
        w_addr  = '0;
        rf_en   = 1'b1;
        kdata   = '0;
        done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    kbase_d = bus.cfg_wbase;
                    nker_d  = bus.cfg_nker;
                    npix_d  = bus.cfg_npix;
                    relu_d  = bus.cfg_relu;
                    ker_d   = '0;
                    pix_d   = '0;
                    tap_d   = '0;
                    state_d = (bus.cfg_nker == '0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                // Read strobe leads the PE capture by one cycle to match SRAM latency.
                if (tap_q < TAP_LAST) begin
                    w_rd   = 1'b1;
                    w_addr = kbase_q + ADDR_W'(tap_q);
                end
                if (tap_q != '0) begin
                    rf_en = 1'b0;
                    kdata = bus.w_data;
                end
                if (tap_q == TAP_LAST) begin
                    tap_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            S_SETTLE: begin
                pix_d = '0;
                if (npix_q == '0) adv_ker = 1'b1;
                else              state_d = S_RUN;
            end
            S_RUN: begin
                if (accept) begin
                    pix_d = pix_q + PIX_W'(1);
                    if (last_pix) adv_ker = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!out_valid_q || bus.out_ready) state_d = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Next kernel may start loading while a result still waits downstream.
        if (adv_ker) begin
            if (last_ker) begin
                state_d = S_DRAIN;
            end else begin
                ker_d   = ker_q + PIX_W'(1);
                kbase_d = kbase_q + ADDR_W'(KTAPS);
                tap_d   = '0;
                state_d = S_LOAD;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tap_q       <= '0;
            ker_q       <= '0;
            pix_q       <= '0;
            nker_q      <= '0;
            npix_q      <= '0;
            kbase_q     <= '0;
            relu_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            ker_q       <= ker_d;
            pix_q       <= pix_d;
            nker_q      <= nker_d;
            npix_q      <= npix_d;
            kbase_q     <= kbase_d;
            relu_q      <= relu_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.busy            = (state_q != S_IDLE);
    assign bus.done            = done;
    assign bus.w_rd            = w_rd;
    assign bus.w_addr          = w_addr;
    assign bus.pe_kernel_rf_en = rf_en;
    assign bus.pe_kernel_data  = kdata;
    assign bus.win_ready       = win_ready;
    assign bus.out_data        = out_data_q;
    assign bus.out_valid       = out_valid_q;

endmodule

// File: tb/tb_conv_pe_ctrl.sv
// Bench for conv_pe_ctrl: table vectors, hand sequences and randomized jobs vs a job-level model.
module tb_conv_pe_ctrl;
    import conv_pe_ctrl_pkg::*;

    localparam int ADDR_W = 12;
    localparam int PIX_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_pe_ctrl_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .SUM_W(KSUM_W)) ifc ();

    conv_pe_ctrl #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .SUM_W(KSUM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int n_chk = 0;
    int n_err = 0;
    int cur[9];
    int fx[9];
    bit fixed_win = 1'b0;
    int last_out;

    assign ifc.prod0 = 25'(cur[0]);
    assign ifc.prod1 = 25'(cur[1]);
    assign ifc.prod2 = 25'(cur[2]);
    assign ifc.prod3 = 25'(cur[3]);
    assign ifc.prod4 = 25'(cur[4]);
    assign ifc.prod5 = 25'(cur[5]);
    assign ifc.prod6 = 25'(cur[6]);
    assign ifc.prod7 = 25'(cur[7]);
    assign ifc.prod8 = 25'(cur[8]);

    function automatic logic [15:0] wmem(input logic [11:0] a);
        return 16'(a) * 16'd741 + 16'h1234;
    endfunction

    // Synchronous weight SRAM: data appears the cycle after the read strobe.
    always @(posedge clk) if (ifc.w_rd) ifc.w_data <= wmem(ifc.w_addr);

    function automatic int rnd_prod();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 4000)) - 2000;
        return int'($urandom_range(0, 33554431)) - 16777216;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_job(input logic [11:0] wb, input int nk, input int np, input bit relu,
                           input int vmode, input int rmode, input int restart_at,
                           input int abort_at, input bit chk_tput);
        int exp_q[$];
        int ea[$];
        int aq[$];
        int dq[$];
        int rf_run = 0, rd_run = 0, rf_bad = 0, rd_bad = 0, n_rf = 0, n_rd = 0;
        int n_out = 0, n_acc = 0, n_done = 0, cyc = 0, done_cyc = 0, last_hs = 0;
        int acc_first = 0, acc_last = 0, bad_a = 0, bad_d = 0, s;
        bit acc_prev = 0, stall_prev = 0, fin = 0, aborted = 0;
        logic [KSUM_W-1:0] held = '0;

        for (int k = 0; k < nk; k++)
            for (int i = 0; i < 9; i++) ea.push_back((int'(wb) + 9 * k + i) % 4096);

        @(posedge clk); #1;
        ifc.cfg_wbase = wb;
        ifc.cfg_nker  = 16'(nk);
        ifc.cfg_npix  = 16'(np);
        ifc.cfg_relu  = relu;
        ifc.start     = 1'b1;
        ifc.win_valid = 1'b0;
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;

        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (abort_at > 0 && n_acc == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_out_valid", ifc.out_valid, 0);
                chk("abort_busy", ifc.busy, 0);
                chk("abort_rf_en", ifc.pe_kernel_rf_en, 1);
                chk("abort_win_ready", ifc.win_ready, 0);
                aborted = 1'b1;
                break;
            end
            if (cyc == 1) chk("busy_after_start", ifc.busy, 1);
            if (acc_prev) chk("out_valid_latency", ifc.out_valid, 1);
            if (stall_prev) begin
                chk("stall_valid_hold", ifc.out_valid, 1);
                chk("stall_data_hold", ifc.out_data, held);
            end
            if (ifc.w_rd) begin
                aq.push_back(int'(ifc.w_addr));
                rd_run++;
            end else if (rd_run > 0) begin
                n_rd++;
                if (rd_run != 9) rd_bad++;
                rd_run = 0;
            end
            if (!ifc.pe_kernel_rf_en) begin
                dq.push_back(int'(ifc.pe_kernel_data));
                rf_run++;
            end else if (rf_run > 0) begin
                n_rf++;
                if (rf_run != 9) rf_bad++;
                rf_run = 0;
            end
            if (ifc.out_valid && ifc.out_ready) begin
                n_out++;
                last_hs  = cyc;
                last_out = int'($signed(ifc.out_data));
                if (exp_q.size() > 0) chk("out_data", last_out, exp_q.pop_front());
            end
            stall_prev = ifc.out_valid && !ifc.out_ready;
            held       = ifc.out_data;
            acc_prev   = ifc.win_valid && ifc.win_ready;
            if (acc_prev) begin
                s = 0;
                foreach (cur[i]) s += cur[i];
                if (relu && s < 0) s = 0;
                exp_q.push_back(s);
                n_acc++;
                if (n_acc == 1) acc_first = cyc;
                acc_last = cyc;
            end
            if (ifc.done) begin
                n_done++;
                done_cyc = cyc;
            end else if (n_done > 0) begin
                chk("busy_after_done", ifc.busy, 0);
                fin = 1'b1;
            end

            @(posedge clk); #1;
            if (cyc == restart_at) begin
                ifc.cfg_wbase = ~wb;
                ifc.cfg_nker  = 16'(nk + 5);
                ifc.cfg_npix  = 16'(np + 3);
                ifc.cfg_relu  = ~relu;
                ifc.start     = 1'b1;
            end else begin
                ifc.start = 1'b0;
            end
            if (acc_prev || !ifc.win_valid) begin
                ifc.win_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                for (int i = 0; i < 9; i++) cur[i] = fixed_win ? fx[i] : rnd_prod();
            end
            case (rmode)
                0:       ifc.out_ready = 1'b1;
                1:       ifc.out_ready = ~ifc.out_ready;
                default: ifc.out_ready = ($urandom_range(0, 1) == 1);
            endcase
        end

        ifc.win_valid = 1'b0;
        ifc.start     = 1'b0;
        if (aborted) begin
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        chk("job_finished", fin, 1);
        if (!fin) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
        for (int i = 0; i < ea.size(); i++) begin
            if (i >= aq.size() || aq[i] != ea[i]) bad_a++;
            if (i >= dq.size() || dq[i] != int'(wmem(12'(ea[i])))) bad_d++;
        end
        chk("w_addr_count", aq.size(), ea.size());
        chk("w_addr_seq_bad", bad_a, 0);
        chk("rf_data_count", dq.size(), ea.size());
        chk("rf_data_bad", bad_d, 0);
        chk("rf_low_runs", n_rf, nk);
        chk("rf_run_len_bad", rf_bad, 0);
        chk("w_rd_runs", n_rd, nk);
        chk("w_rd_run_len_bad", rd_bad, 0);
        chk("n_outputs", n_out, nk * np);
        chk("done_count", n_done, 1);
        if (n_out > 0) chk("done_after_last_hs", done_cyc > last_hs, 1);
        if (nk == 0) chk("done_latency", done_cyc <= 2, 1);
        if (chk_tput) chk("throughput_span", acc_last - acc_first, np - 1);
    endtask

    typedef struct {
        int pa;
        int pb;
        int pc;
        bit relu;
        int exp;
    } vec_t;

    vec_t tv[9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ifc.start     = 1'b0;
        ifc.cfg_wbase = '0;
        ifc.cfg_nker  = '0;
        ifc.cfg_npix  = '0;
        ifc.cfg_relu  = 1'b0;
        ifc.win_valid = 1'b0;
        ifc.out_ready = 1'b1;
        foreach (cur[i]) cur[i] = 0;

        #12;
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.done, 0);
        chk("rst_w_rd", ifc.w_rd, 0);
        chk("rst_w_addr", ifc.w_addr, 0);
        chk("rst_rf_en", ifc.pe_kernel_rf_en, 1);
        chk("rst_kdata", ifc.pe_kernel_data, 0);
        chk("rst_win_ready", ifc.win_ready, 0);
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_out_data", ifc.out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Kernel load only, no windows.
        run_job(12'h100, 1, 0, 1'b0, 0, 0, 0, 0, 1'b0);

        // Single-window vectors: p0 = pa, odd taps = pb, even taps 2..8 = pc.
        tv[0] = '{1000, 1000, 1000, 1'b0, 9000};
        tv[1] = '{-1000, -1000, -1000, 1'b1, 0};
        tv[2] = '{-16777216, 0, 0, 1'b0, -16777216};
        tv[3] = '{16777215, 16777215, 16777215, 1'b0, 150994935};
        tv[4] = '{-16777216, -16777216, -16777216, 1'b0, -150994944};
        tv[5] = '{4, -3, 5, 1'b1, 12};
        tv[6] = '{-1000, -1000, -1000, 1'b0, -9000};
        tv[7] = '{0, -1, 0, 1'b1, 0};
        tv[8] = '{0, -1, 0, 1'b0, -4};
        fixed_win = 1'b1;
        for (int v = 0; v < 9; v++) begin
            fx[0] = tv[v].pa;
            for (int i = 1; i < 9; i++) fx[i] = (i % 2 == 1) ? tv[v].pb : tv[v].pc;
            last_out = 12345678;
            run_job(12'h040, 1, 1, tv[v].relu, 0, 0, 0, 0, 1'b0);
            chk($sformatf("vec%0d_out", v), last_out, tv[v].exp);
        end
        fixed_win = 1'b0;

        // Streaming: backpressure 1010, then full throughput.
        run_job(12'h050, 1, 8, 1'b0, 0, 1, 0, 0, 1'b0);
        run_job(12'h050, 1, 8, 1'b1, 0, 0, 0, 0, 1'b1);

        // Multi-kernel with random backpressure.
        run_job(12'h200, 3, 2, 1'b0, 0, 2, 0, 0, 1'b0);

        // Zero kernels, then a start pulse mid-job that must be ignored.
        run_job(12'h007, 0, 3, 1'b0, 0, 0, 0, 0, 1'b0);
        run_job(12'h300, 2, 4, 1'b0, 1, 2, 15, 0, 1'b0);

        // Reset after three windows, then a clean full job.
        run_job(12'h010, 1, 8, 1'b0, 0, 0, 0, 3, 1'b0);
        run_job(12'h010, 1, 8, 1'b0, 0, 0, 0, 0, 1'b1);

        // Address wrap across the top of weight memory.
        run_job(12'hFFA, 2, 1, 1'b1, 1, 2, 0, 0, 1'b0);

        for (int j = 0; j < 8; j++)
            run_job(12'($urandom_range(0, 4095)), int'($urandom_range(1, 3)),
                    int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/conv_pe_ctrl.md
Name: conv_pe_ctrl

Overview:
- Sequencer for the 9-tap 3x3 PE multiplier array.
- Fetches each kernel's 9 weights from weight memory and loads them serially into the PE.
- Then streams a configured number of pixel windows through the PE, reduces the 9 products to one sum, applies optional ReLU, and presents the result on a valid/ready output.
- Repeats for cfg_nker kernels per start. Sits between the line buffer / weight SRAM and the output-feature writer.

Parameters:
- ADDR_W, 12, weight memory address width
- PIX_W, 16, width of pixel-count and kernel-count config fields
- SUM_W, 29, output sum width (25-bit product + 4 bits growth for 9 terms)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse, begins a job; ignored while busy
- cfg_wbase  in  ADDR_W  weight base address, sampled on start
- cfg_nker  in  PIX_W  number of kernels, sampled on start
- cfg_npix  in  PIX_W  windows per kernel, sampled on start
- cfg_relu  in  1  clamp negative sums to 0, sampled on start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at job end
- w_rd  out  1  weight read strobe
- w_addr  out  ADDR_W  weight read address
- w_data  in  16  signed weight; valid exactly 1 cycle after w_rd
- pe_kernel_rf_en  out  1  low = PE is capturing weights
- pe_kernel_data  out  16  weight to PE
- prod0..prod8  in  25 each  signed PE products (combinational from the current window)
- win_valid  in  1  line buffer presents a window on the PE R inputs
- win_ready  out  1  controller consumes the window this cycle
- out_data  out  SUM_W  signed result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts

Behaviour:
- Reset values: state IDLE, busy=0, done=0, w_rd=0, w_addr=0, pe_kernel_rf_en=1, pe_kernel_data=0, win_ready=0, out_valid=0, out_data=0, all counters 0.
- States: IDLE, LOAD, SETTLE, RUN, DRAIN, FIN.
- IDLE:
  - start latches cfg_*, kernel index k=0, and moves to LOAD.
  - If cfg_nker==0, go to FIN instead.
- LOAD (10 cycles):
  - Cycles 0..8: w_rd=1, w_addr=wbase+9*k+i.
  - Cycles 1..9: pe_kernel_rf_en=0, pe_kernel_data=w_data, so exactly 9 consecutive rf_en-low cycles carry weights k0..k8 in order.
  - pe_kernel_rf_en is 1 in every other state. Then go to SETTLE.
- SETTLE: 1 cycle with rf_en=1 so the PE kernel registers are stable. Then go to RUN, with window counter p=0.
  - If npix==0, skip RUN and go straight to next-kernel handling.
- RUN:
  - win_ready = !out_valid || out_ready.
  - On win_valid && win_ready: out_data <= sum(prod0..prod8), sign-extended to SUM_W; if relu and the sum is negative, out_data <= 0. Also out_valid <= 1 and p++.
  - Latency is 1 cycle from window accept to out_valid.
  - out_valid clears on out_ready unless a new window is accepted in the same cycle; simultaneous accept and drain gives full throughput of 1 window per cycle.
  - out_data is held stable while out_valid && !out_ready.
  - When the last window (p==npix-1) is accepted: if k<nker-1, k++ and go to LOAD; else go to DRAIN.
  - LOAD may begin while out_valid is still pending, because it does not touch the output register.
- DRAIN: wait until out_valid==0 or out_ready, then go to FIN.
- FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Arithmetic: a full-precision signed adder tree; no saturation is needed at SUM_W=29.
- Address arithmetic wraps modulo 2^ADDR_W.
- start while busy has no effect. win_valid outside RUN is ignored (win_ready=0).
- rst asserted mid-job returns to IDLE immediately with the reset values. No done pulse is issued, and any pending result is discarded.

Decomposition:
- Shared package holds the state encoding enum, the constant KTAPS=9, and SUM_W derivation (25 + clog2(KTAPS)).
- One sub-module, pe_sum_tree: combinational 9-input signed adder tree plus ReLU mux. The FSM, counters and output register stay in conv_pe_ctrl.

Test Plan:
- Kernel load: wbase=0x100, nker=1, npix=0.
  - w_addr steps 0x100..0x108 on 9 consecutive cycles.
  - rf_en is low for exactly 9 cycles with pe_kernel_data equal to the memory words in order.
  - done fires; no output is produced.
- Single window: all prod=+1000, relu=0 -> out_data=9000 one cycle after accept.
  - All prod=-1000, relu=1 -> out_data=0.
  - prod0=-(2^24), others 0, relu=0 -> out_data=-16777216.
- Streaming with backpressure: npix=8, win_valid held high, out_ready toggled 1010.
  - Exactly 8 outputs, none lost or duplicated.
  - out_data is stable while stalled; throughput is 1 per cycle when out_ready=1.
- Multi-kernel: nker=3, npix=2 -> three LOAD phases at addresses wbase, wbase+9, wbase+18; 6 outputs; done after the final handshake.
- Edge config: nker=0 -> done 1–2 cycles after start, no w_rd.
  - start pulsed again mid-job -> ignored; config is unchanged.
- Reset mid-RUN: rst asserted after 3 of 8 windows -> out_valid=0, busy=0, rf_en=1 in the same cycle.
  - A new start afterwards runs a clean full job.
